// File: rtl/tpu_pkg.sv
// tpu_pkg: opcodes, sequencer states and the packed command record shared by the sequencer files.
// Dims and submat fields are stored at a fixed maximum width so one record type serves every parameter set.
package tpu_pkg;
  localparam logic [2:0] OP_WR_INPUT    = 3'b001;
  localparam logic [2:0] OP_WR_WEIGHT   = 3'b010;
  localparam logic [2:0] OP_LOAD_WEIGHT = 3'b011;
  localparam logic [2:0] OP_MATMUL      = 3'b100;
  localparam logic [2:0] OP_CLEAR       = 3'b111;
  localparam int DIM_MAX_W = 8;
  localparam int SUB_MAX_W = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, STREAM, WAIT_DONE} state_e;
  typedef struct packed {
    logic [2:0]           opcode;
    logic [DIM_MAX_W-1:0] dim_1;
    logic [DIM_MAX_W-1:0] dim_2;
    logic [DIM_MAX_W-1:0] dim_3;
    logic [7:0]           addr_1;
    logic [SUB_MAX_W-1:0] submat_row;
    logic [SUB_MAX_W-1:0] submat_col;
  } tpu_cmd_t;
  function automatic logic op_is_wr(input logic [2:0] op);
    return op == OP_WR_INPUT || op == OP_WR_WEIGHT;
  endfunction
  function automatic logic op_legal(input logic [2:0] op);
    return op_is_wr(op) || op == OP_LOAD_WEIGHT || op == OP_MATMUL || op == OP_CLEAR;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through synchronous FIFO.
// Ports: clk, reset (sync, active-high), push/wdata, pop/rdata (head), count, full, empty.
// Push when full and pop when empty are ignored; DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  always_comb begin
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/tpu_cmd_sequencer.sv
// tpu_cmd_sequencer: queues host commands and rows, issues one command at a time to top via start/done.
// Ports: cmd_* command queue in, row_* row queue in, tpu_* command/row buses out, tpu_done/tpu_fifo_ready in,
// busy, sticky err_opcode/err_timeout (cleared by err_clear), cmd_count of completed commands.
// Macro TPU_SEQ_TIMEOUT_EN adds a WAIT_DONE watchdog of TIMEOUT_CYCLES; without it err_timeout is 0.
module tpu_cmd_sequencer
  import tpu_pkg::*;
#(
  parameter int WIDTH_HEIGHT   = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_MAT_WH     = 128,
  parameter int CMD_DEPTH      = 8,
  parameter int ROW_DEPTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int DW = $clog2(WIDTH_HEIGHT),
  localparam int SW = $clog2(MAX_MAT_WH / WIDTH_HEIGHT),
  localparam int RW = WIDTH_HEIGHT * DATA_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_opcode,
  input  logic [DW-1:0] cmd_dim_1,
  input  logic [DW-1:0] cmd_dim_2,
  input  logic [DW-1:0] cmd_dim_3,
  input  logic [7:0]    cmd_addr_1,
  input  logic [SW-1:0] cmd_submat_row,
  input  logic [SW-1:0] cmd_submat_col,
  input  logic          row_valid,
  output logic          row_ready,
  input  logic [RW-1:0] row_data,
  input  logic          err_clear,
  output logic          tpu_start,
  output logic [2:0]    tpu_opcode,
  output logic [DW-1:0] tpu_dim_1,
  output logic [DW-1:0] tpu_dim_2,
  output logic [DW-1:0] tpu_dim_3,
  output logic [7:0]    tpu_addr_1,
  output logic [SW-1:0] tpu_submat_row,
  output logic [SW-1:0] tpu_submat_col,
  output logic [RW-1:0] tpu_input_wr_data,
  output logic [RW-1:0] tpu_weight_wr_data,
  input  logic          tpu_done,
  input  logic          tpu_fifo_ready,
  output logic          busy,
  output logic          err_opcode,
  output logic          err_timeout,
  output logic [15:0]   cmd_count
);
  localparam int CCW = $clog2(CMD_DEPTH) + 1;
  localparam int RCW = $clog2(ROW_DEPTH) + 1;
  state_e state_q, state_d;
  tpu_cmd_t cmd_in, cmd_head;
  logic cmd_full, cmd_empty, cmd_pop, row_full, row_empty, row_pop;
  logic [CCW-1:0] cmd_cnt;
  logic [RCW-1:0] row_cnt;
  logic [RW-1:0] row_head;
  logic head_ok, head_go, err_opcode_set, err_opcode_q, err_opcode_d;
  logic [2:0] tpu_opcode_q, tpu_opcode_d;
  logic [DW-1:0] tpu_dim_1_q, tpu_dim_1_d, tpu_dim_2_q, tpu_dim_2_d, tpu_dim_3_q, tpu_dim_3_d, row_idx_q, row_idx_d;
  logic [7:0] tpu_addr_1_q, tpu_addr_1_d;
  logic [SW-1:0] tpu_submat_row_q, tpu_submat_row_d, tpu_submat_col_q, tpu_submat_col_d;
  logic [15:0] cmd_count_q, cmd_count_d;
  assign cmd_in = '{opcode: cmd_opcode, dim_1: DIM_MAX_W'(cmd_dim_1), dim_2: DIM_MAX_W'(cmd_dim_2),
                    dim_3: DIM_MAX_W'(cmd_dim_3), addr_1: cmd_addr_1,
                    submat_row: SUB_MAX_W'(cmd_submat_row), submat_col: SUB_MAX_W'(cmd_submat_col)};
  assign cmd_ready = !cmd_full;
  assign row_ready = !row_full;
  sync_fifo #(.WIDTH($bits(tpu_cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(clk), .reset(reset), .push(cmd_valid && cmd_ready), .wdata(cmd_in), .pop(cmd_pop),
    .rdata(cmd_head), .count(cmd_cnt), .full(cmd_full), .empty(cmd_empty)
  );
  sync_fifo #(.WIDTH(RW), .DEPTH(ROW_DEPTH)) u_row_fifo (
    .clk(clk), .reset(reset), .push(row_valid && row_ready), .wdata(row_data), .pop(row_pop),
    .rdata(row_head), .count(row_cnt), .full(row_full), .empty(row_empty)
  );
  // Field bits above the port widths are always zero after zero-extension; any set bit marks a corrupt entry.
  assign head_ok = op_legal(cmd_head.opcode) &&
    {cmd_head.dim_1 >> DW, cmd_head.dim_2 >> DW, cmd_head.dim_3 >> DW,
     cmd_head.submat_row >> SW, cmd_head.submat_col >> SW} == '0;
  // Writes need every row of the tile already queued so STREAM never stalls.
  assign head_go = op_is_wr(cmd_head.opcode) ? 32'(row_cnt) >= 32'(cmd_head.dim_1) + 32'd1 :
                   cmd_head.opcode == OP_MATMUL ? tpu_fifo_ready : 1'b1;
`ifdef TPU_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] wait_q, wait_d;
  logic err_timeout_q, err_timeout_d, timeout_hit;
  assign timeout_hit = state_q == WAIT_DONE && !tpu_done && wait_q == TW'(TIMEOUT_CYCLES - 1);
  assign wait_d = state_q == WAIT_DONE ? wait_q + TW'(1) : '0;
  assign err_timeout_d = timeout_hit | (err_timeout_q & !err_clear);
  assign err_timeout = err_timeout_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q        <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wait_q        <= wait_d;
      err_timeout_q <= err_timeout_d;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif
  always_comb begin
    state_d          = state_q;
    cmd_pop          = 1'b0;
    row_pop          = 1'b0;
    err_opcode_set   = 1'b0;
    tpu_opcode_d     = tpu_opcode_q;
    tpu_dim_1_d      = tpu_dim_1_q;
    tpu_dim_2_d      = tpu_dim_2_q;
    tpu_dim_3_d      = tpu_dim_3_q;
    tpu_addr_1_d     = tpu_addr_1_q;
    tpu_submat_row_d = tpu_submat_row_q;
    tpu_submat_col_d = tpu_submat_col_q;
    row_idx_d        = row_idx_q;
    cmd_count_d      = cmd_count_q;
    case (state_q)
      IDLE: if (!cmd_empty) begin
        if (!head_ok) begin
          cmd_pop        = 1'b1;
          err_opcode_set = 1'b1;
        end else if (head_go) begin
          cmd_pop          = 1'b1;
          tpu_opcode_d     = cmd_head.opcode;
          tpu_dim_1_d      = cmd_head.dim_1[DW-1:0];
          tpu_dim_2_d      = cmd_head.dim_2[DW-1:0];
          tpu_dim_3_d      = cmd_head.dim_3[DW-1:0];
          tpu_addr_1_d     = cmd_head.addr_1;
          tpu_submat_row_d = cmd_head.submat_row[SW-1:0];
          tpu_submat_col_d = cmd_head.submat_col[SW-1:0];
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        row_idx_d = '0;
        state_d   = op_is_wr(tpu_opcode_q) ? STREAM : WAIT_DONE;
      end
      STREAM: begin
        row_pop   = !row_empty;
        row_idx_d = row_idx_q + DW'(1);
        state_d   = row_idx_q == tpu_dim_1_q ? WAIT_DONE : STREAM;
      end
      WAIT_DONE: if (tpu_done) begin
        cmd_count_d = cmd_count_q + 16'd1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef TPU_SEQ_TIMEOUT_EN
    if (timeout_hit) state_d = IDLE;
`endif
  end
  assign err_opcode_d       = err_opcode_set | (err_opcode_q & !err_clear);
  assign tpu_start          = state_q == ISSUE;
  assign tpu_input_wr_data  = state_q == STREAM && tpu_opcode_q == OP_WR_INPUT ? row_head : '0;
  assign tpu_weight_wr_data = state_q == STREAM && tpu_opcode_q == OP_WR_WEIGHT ? row_head : '0;
  assign busy               = state_q != IDLE || cmd_cnt != '0;
  assign err_opcode         = err_opcode_q;
  assign cmd_count          = cmd_count_q;
  assign tpu_opcode         = tpu_opcode_q;
  assign tpu_dim_1          = tpu_dim_1_q;
  assign tpu_dim_2          = tpu_dim_2_q;
  assign tpu_dim_3          = tpu_dim_3_q;
  assign tpu_addr_1         = tpu_addr_1_q;
  assign tpu_submat_row     = tpu_submat_row_q;
  assign tpu_submat_col     = tpu_submat_col_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      err_opcode_q     <= 1'b0;
      tpu_opcode_q     <= '0;
      tpu_dim_1_q      <= '0;
      tpu_dim_2_q      <= '0;
      tpu_dim_3_q      <= '0;
      tpu_addr_1_q     <= '0;
      tpu_submat_row_q <= '0;
      tpu_submat_col_q <= '0;
      row_idx_q        <= '0;
      cmd_count_q      <= '0;
    end else begin
      state_q          <= state_d;
      err_opcode_q     <= err_opcode_d;
      tpu_opcode_q     <= tpu_opcode_d;
      tpu_dim_1_q      <= tpu_dim_1_d;
      tpu_dim_2_q      <= tpu_dim_2_d;
      tpu_dim_3_q      <= tpu_dim_3_d;
      tpu_addr_1_q     <= tpu_addr_1_d;
      tpu_submat_row_q <= tpu_submat_row_d;
      tpu_submat_col_q <= tpu_submat_col_d;
      row_idx_q        <= row_idx_d;
      cmd_count_q      <= cmd_count_d;
    end
  end
endmodule
